// File: rtl/adc_frame_buffer.sv
// Single-frame capture buffer: arm-triggered, optionally decimated capture of the ADC word
// into block RAM, converted to two's complement and replayed over a valid/ready stream.
module adc_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              adc_dci,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              fmt_offset,
  input  logic [7:0]        decim,
  input  logic              arm,
  input  logic              abort,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t              r_state;
  logic [7:0]          r_decim;
  logic [7:0]          r_dec_cnt;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_all;
  logic                r_q_valid;
  logic                r_q_last;
  logic [DATA_W-1:0]   r_ram_q;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_valid;
  logic                r_m_last;
  logic                r_done;
  logic [15:0]         r_frame_cnt;
  logic [DATA_W-1:0]   r_mem [FRAME_LEN];

  logic [DATA_W-1:0]   w_conv;
  logic                w_wr_en;
  logic                w_hs;
  logic                w_s2_load;
  logic                w_s1_adv;
  logic                w_rd_en;
  logic                w_final;

  // Handshake: a sample transfers on any rising edge where m_valid & m_ready are both high;
  // m_data/m_last are held while m_valid is high and m_ready is low.
  assign w_conv    = fmt_offset ? {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]} : adc_data;
  assign w_wr_en   = (r_state == S_CAPTURE) && (r_dec_cnt == 8'd0);
  assign w_hs      = r_m_valid && m_ready;
  // Two-stage pipe (RAM read register, then output register) so a stall never loses a read.
  assign w_s2_load = r_q_valid && (!r_m_valid || w_hs);
  assign w_s1_adv  = !r_q_valid || w_s2_load;
  assign w_rd_en   = (r_state == S_READOUT) && !r_rd_all && w_s1_adv;
  assign w_final   = w_hs && r_m_last;

  always_ff @(posedge adc_dci) begin
    if (w_wr_en) r_mem[r_wr_addr] <= w_conv;
    if (w_rd_en) r_ram_q <= r_mem[r_rd_addr];
  end

  always_ff @(posedge adc_dci) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_decim     <= 8'd0;
      r_dec_cnt   <= 8'd0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_rd_all    <= 1'b0;
      r_q_valid   <= 1'b0;
      r_q_last    <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_q_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (arm) begin
              r_decim   <= decim;
              r_dec_cnt <= 8'd0;
              r_wr_addr <= '0;
              r_state   <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (w_wr_en) begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
              r_dec_cnt <= r_decim;
              if (r_wr_addr == LAST_ADDR) begin
                r_state   <= S_READOUT;
                r_rd_addr <= '0;
                r_rd_all  <= 1'b0;
                r_q_valid <= 1'b0;
              end
            end else begin
              r_dec_cnt <= r_dec_cnt - 8'd1;
            end
          end
          S_READOUT: begin
            if (w_rd_en) begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_q_last  <= (r_rd_addr == LAST_ADDR);
              if (r_rd_addr == LAST_ADDR) r_rd_all <= 1'b1;
            end
            if (w_rd_en)        r_q_valid <= 1'b1;
            else if (w_s2_load) r_q_valid <= 1'b0;
            if (w_s2_load) begin
              r_m_data  <= r_ram_q;
              r_m_valid <= 1'b1;
              r_m_last  <= r_q_last;
            end else if (w_hs) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
            end
            if (w_final) begin
              r_state     <= S_IDLE;
              r_m_valid   <= 1'b0;
              r_m_last    <= 1'b0;
              r_q_valid   <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Bench for adc_frame_buffer with FRAME_LEN=16: table of frame vectors plus hand-written
// abort/reset corner sequences.
module tb_adc_frame_buffer;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 4;

  logic              adc_dci;
  logic              sys_rst;
  logic [DATA_W-1:0] adc_data;
  logic              fmt_offset;
  logic [7:0]        decim;
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_frames = 0;

  typedef struct {
    logic [7:0]  decim;
    logic        fmt;
    logic [15:0] base;
    logic [15:0] exp0;
    logic [15:0] estep;
    logic        rnd_ready;
    logic        noise;
  } vec_t;

  vec_t vecs[5];

  adc_frame_buffer #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .adc_dci(adc_dci), .sys_rst(sys_rst), .adc_data(adc_data), .fmt_offset(fmt_offset),
    .decim(decim), .arm(arm), .abort(abort), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    adc_dci = 1'b0;
    forever #5 adc_dci = ~adc_dci;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge adc_dci);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 300) begin
      adc_data = adc_data + 16'd1;
      step();
      lat++;
    end
    chk("valid_seen", m_valid, 1'b1);
  endtask

  task automatic run_frame(input vec_t v);
    int lat;
    int k;
    int cyc;
    logic [15:0] exp_v;
    logic [15:0] prev_d;
    logic        prev_last;
    logic        prev_stall;
    decim      = v.decim;
    fmt_offset = v.fmt;
    adc_data   = v.base - 16'd1;
    m_ready    = 1'b1;
    arm        = 1'b1;
    step();
    arm = 1'b0;
    chk("busy_after_arm", busy, 1'b1);
    lat = 0;
    while (!m_valid && lat < 300) begin
      adc_data = adc_data + 16'd1;
      arm = (v.noise && lat == 3);
      step();
      lat++;
    end
    arm = 1'b0;
    chk("first_valid_latency", lat, 3 + (FRAME_LEN - 1) * (int'(v.decim) + 1));
    k = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_last = 1'b0;
    while (k < FRAME_LEN && cyc < 400) begin
      arm = (v.noise && k == 5);
      m_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, prev_d);
        chk("stall_last", m_last, prev_last);
      end
      if (!v.rnd_ready) chk("no_bubble", m_valid, 1'b1);
      chk("no_early_done", done, 1'b0);
      if (m_valid && m_ready) begin
        exp_v = v.exp0 + 16'(k) * v.estep;
        chk("sample_data", m_data, exp_v);
        chk("sample_last", m_last, (k == FRAME_LEN - 1));
        k++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_last  = m_last;
      adc_data   = adc_data + 16'd1;
      step();
      cyc++;
    end
    arm = 1'b0;
    m_ready = 1'b1;
    chk("all_delivered", k, FRAME_LEN);
    exp_frames++;
    chk("done_pulse", done, 1'b1);
    chk("valid_dropped", m_valid, 1'b0);
    chk("busy_dropped", busy, 1'b0);
    chk("frame_cnt", frame_cnt, exp_frames[15:0]);
    chk("state_idle", dbg_state, 2'd0);
  endtask

  task automatic check_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (done || m_valid || busy) seen = 1'b1;
      adc_data = 16'($urandom);
      step();
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    int lat;
    logic bad;
    vecs[0] = '{decim: 8'd0, fmt: 1'b0, base: 16'h0000, exp0: 16'h0000, estep: 16'd1, rnd_ready: 1'b0, noise: 1'b0};
    vecs[1] = '{decim: 8'd2, fmt: 1'b1, base: 16'h8000, exp0: 16'h0000, estep: 16'd3, rnd_ready: 1'b0, noise: 1'b0};
    vecs[2] = '{decim: 8'd0, fmt: 1'b0, base: 16'h0000, exp0: 16'h0000, estep: 16'd1, rnd_ready: 1'b1, noise: 1'b0};
    vecs[3] = '{decim: 8'd1, fmt: 1'b1, base: 16'h0005, exp0: 16'h8005, estep: 16'd2, rnd_ready: 1'b1, noise: 1'b1};
    vecs[4] = '{decim: 8'd0, fmt: 1'b0, base: 16'hFFF8, exp0: 16'hFFF8, estep: 16'd1, rnd_ready: 1'b0, noise: 1'b1};

    sys_rst = 1'b1; adc_data = '0; fmt_offset = 1'b0; decim = 8'd0;
    arm = 1'b0; abort = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_data = 16'($urandom);
      step();
    end
    sys_rst = 1'b0;
    chk("rst_m_data", m_data, 16'h0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adc_data = 16'($urandom);
      step();
      if (m_data != 0 || m_valid || m_last || busy || done || frame_cnt != 0) bad = 1'b1;
    end
    chk("idle_outputs_zero", bad, 1'b0);

    // back-to-back vectors: each arm lands on the cycle right after the previous done
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // abort mid-capture
    decim = 8'd0; fmt_offset = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cap_busy", busy, 1'b0);
    chk("abort_cap_state", dbg_state, 2'd0);
    check_quiet("abort_cap_quiet", 30);
    chk("abort_cap_frame_cnt", frame_cnt, exp_frames[15:0]);

    // abort mid-readout after 5 handshakes
    arm = 1'b1;
    step();
    arm = 1'b0;
    wait_valid(lat);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_rd_valid", m_valid, 1'b0);
    chk("abort_rd_last", m_last, 1'b0);
    chk("abort_rd_busy", busy, 1'b0);
    check_quiet("abort_rd_quiet", 10);
    chk("abort_rd_frame_cnt", frame_cnt, exp_frames[15:0]);

    run_frame(vecs[0]);

    // abort coincident with the final handshake wins
    arm = 1'b1;
    step();
    arm = 1'b0;
    wait_valid(lat);
    m_ready = 1'b1;
    for (int i = 0; i < FRAME_LEN - 1; i++) step();
    chk("pre_final_last", m_last, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_final_done", done, 1'b0);
    chk("abort_final_valid", m_valid, 1'b0);
    chk("abort_final_frame_cnt", frame_cnt, exp_frames[15:0]);

    // reset mid-readout clears the frame counter
    arm = 1'b1;
    step();
    arm = 1'b0;
    wait_valid(lat);
    step();
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    exp_frames = 0;
    chk("rst_rd_valid", m_valid, 1'b0);
    chk("rst_rd_data", m_data, 16'h0);
    chk("rst_rd_busy", busy, 1'b0);
    chk("rst_rd_frame_cnt", frame_cnt, 16'h0);

    run_frame(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_buffer.md
# adc_frame_buffer

Frame-capture stage that sits directly downstream of the LTC2208 capture register in the ADC clock domain. On an arm pulse it collects one frame of `FRAME_LEN` (optionally decimated) samples from the registered ADC word into internal block RAM. It converts each sample to two's complement and then streams the frame out over a valid/ready interface to the FFT stage. One frame is in flight at a time; the block never overwrites a frame that has not been fully read out.

## Interface

Parameters:
- `DATA_W`, 16, sample width (matches the ADC capture register)
- `FRAME_LEN`, 1024, samples per frame; power of two, 16..65536
- `ADDR_W`, 10, log2(`FRAME_LEN`)

Ports (one clock; reset is synchronous and active-high):
- `adc_dci`  in  1  ADC data clock; all logic on its rising edge
- `sys_rst`  in  1  synchronous, active-high reset
- `adc_data`  in  `DATA_W`  registered ADC sample, new value every cycle
- `fmt_offset`  in  1  1 = input is offset binary (MSB inverted on capture); 0 = already two's complement
- `decim`  in  8  keep 1 of every `decim`+1 samples; sampled at arm
- `arm`  in  1  single-cycle start request
- `abort`  in  1  cancel capture/readout, return to IDLE
- `m_data`  out  `DATA_W`  output sample, two's complement
- `m_valid`  out  1  `m_data` valid
- `m_ready`  in  1  downstream accepts when `m_valid` & `m_ready`
- `m_last`  out  1  marks sample `FRAME_LEN`-1 of the frame
- `busy`  out  1  high in CAPTURE or READOUT
- `done`  out  1  one-cycle pulse after the final output handshake
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0

## Operation

- States: IDLE, CAPTURE, READOUT.
- IDLE: `busy`=0, `m_valid`=0. `arm`=1 and `abort`=0: latch `decim` into `decim_reg`, clear write address and decimation counter, go to CAPTURE. `arm` outside IDLE is ignored.
- CAPTURE: each cycle with decimation counter = 0, write the converted `adc_data` to RAM[wr_addr], increment wr_addr, reload counter with `decim_reg`; otherwise decrement the counter. After the write at wr_addr = `FRAME_LEN`-1, go to READOUT.
- Conversion: `fmt_offset`=1 → `{~adc_data[DATA_W-1], adc_data[DATA_W-2:0]}`; else pass-through. `fmt_offset` is applied per sample, not latched.
- READOUT: present RAM[0..`FRAME_LEN`-1] in order. `m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0. No bubbles while `m_ready` is held high: one sample per cycle. `m_last`=1 only with sample `FRAME_LEN`-1.
- After the handshake on the `m_last` sample: `m_valid`→0, `done`=1 for one cycle, `frame_cnt`+1, go to IDLE.
- `abort`=1 in any state: next cycle is IDLE. `m_valid`, `m_last` and `busy` drop. No `done`, and `frame_cnt` is unchanged. `abort` takes priority over `arm` and over a coincident final handshake.
- RAM contents are not reset; only control state is reset.

## Timing

- Reset (`sys_rst`=1 at an edge): state IDLE. `m_data`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0, `frame_cnt`=0. Reset mid-capture or mid-readout behaves like `abort`, and also clears `frame_cnt`.
- `arm` sampled at edge t: `busy`=1 from t+1. Sample 0 is the `adc_data` present at edge t+1.
- Decimation `decim`=D: samples k·(D+1) after sample 0 are stored. The last write happens at edge t+1+(`FRAME_LEN`-1)(D+1).
- If the last write is at edge w, `m_valid` first rises at edge w+2 (1-cycle RAM read plus output register), with `m_data` = sample 0.
- Handshake at edge h (not last): the next sample is valid at h+1 (prefetch/skid; no throughput loss).
- Final handshake at edge h: `m_valid`=0 and `done`=1 at h+1, `busy`=0 at h+1, `frame_cnt` updated at h+1. A new `arm` is accepted from edge h+1.

## Test plan

- Reset then idle: `sys_rst` high 3 cycles, random `adc_data` → all outputs 0, `busy`=0 for 20 cycles with no `arm`.
- Ramp capture, `decim`=0, `fmt_offset`=0, `FRAME_LEN`=16, `m_ready`=1: `adc_data`=0,1,2…, `arm` at t → `m_valid` rises at t+18, outputs 0..15 on consecutive cycles, `m_last` with 15, `done` one cycle later, `frame_cnt`=1.
- Offset binary plus decimation: `fmt_offset`=1, `decim`=2, `adc_data` ramp starting at 0x8000 → outputs 0x0000, 0x0003, 0x0006, …, 0x002D (16 samples).
- Backpressure: `m_ready` toggles with a random 50% pattern → all 16 samples delivered once, in order; `m_data` stable in every stall cycle; `m_last` only on sample 15.
- Abort: `abort` mid-capture, then mid-readout (after 5 handshakes) → IDLE next cycle, `m_valid`=0, no `done`, `frame_cnt` unchanged; next `arm` captures a fresh full frame.
- Arm ignored while busy: `arm` pulses during CAPTURE and READOUT → frame unaffected, exactly one `done`; an `arm` on the cycle after `done` starts a new frame.
